// File: rtl/reservation_station.sv
// ============================================================================
// reservation_station : buffers dispatched ALU ops, snoops both CDBs, issues
//                       the lowest-index ready entry per cycle.  Rev 1.0
// ============================================================================
`default_nettype none

module reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int ROB_ID_W = 4,
  parameter int OP_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_signal,
  input  logic                ena_rs,
  input  logic [ROB_ID_W-1:0] rd_alias_from_dsp,
  input  logic [OP_W-1:0]     optype_from_dsp,
  input  logic [31:0]         pc_from_dsp,
  input  logic [ROB_ID_W-1:0] Qi_from_dsp,
  input  logic [ROB_ID_W-1:0] Qj_from_dsp,
  input  logic [31:0]         Vi_from_dsp,
  input  logic [31:0]         Vj_from_dsp,
  input  logic [31:0]         imm_from_dsp,
  output logic                rs_full,
  input  logic                alu_has_result,
  input  logic [ROB_ID_W-1:0] alias_from_alu,
  input  logic [31:0]         result_from_alu,
  input  logic                lsb_has_result,
  input  logic [ROB_ID_W-1:0] alias_from_lsb,
  input  logic [31:0]         result_from_lsb,
  output logic                ena_alu,
  output logic [ROB_ID_W-1:0] rd_alias_2alu,
  output logic [OP_W-1:0]     optype_2alu,
  output logic [31:0]         pc_2alu,
  output logic [31:0]         Vi_2alu,
  output logic [31:0]         Vj_2alu,
  output logic [31:0]         imm_2alu
);

  localparam int             IDX_W      = $clog2(RS_SIZE);
  localparam logic [IDX_W:0] C_MIN_FREE = (IDX_W + 1)'(2);

  logic [RS_SIZE-1:0]  r_valid;
  logic [ROB_ID_W-1:0] r_alias [RS_SIZE];
  logic [OP_W-1:0]     r_op    [RS_SIZE];
  logic [31:0]         r_pc    [RS_SIZE];
  logic [ROB_ID_W-1:0] r_qi    [RS_SIZE];
  logic [ROB_ID_W-1:0] r_qj    [RS_SIZE];
  logic [31:0]         r_vi    [RS_SIZE];
  logic [31:0]         r_vj    [RS_SIZE];
  logic [31:0]         r_imm   [RS_SIZE];

  logic             w_has_free;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_has_sel;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W:0]   w_free_cnt;

  // Alias 0 means "already resolved", so it can never match a broadcast.
  function automatic logic cdb_hit(input logic [ROB_ID_W-1:0] q);
    return (q != '0) && ((lsb_has_result && (alias_from_lsb == q)) ||
                         (alu_has_result && (alias_from_alu == q)));
  endfunction

  function automatic logic [31:0] cdb_data(input logic [ROB_ID_W-1:0] q);
    return (lsb_has_result && (alias_from_lsb == q)) ? result_from_lsb : result_from_alu;
  endfunction

  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_has_sel  = 1'b0;
    w_sel_idx  = '0;
    w_free_cnt = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_valid[i] && (r_qi[i] == '0) && (r_qj[i] == '0)) begin
        w_has_sel = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
      w_free_cnt = w_free_cnt + (IDX_W + 1)'(!r_valid[i]);
    end
  end

  assign rs_full = (w_free_cnt < C_MIN_FREE);

  // Payload needs no reset: an entry's fields are only looked at while valid.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_valid[i] && cdb_hit(r_qi[i])) begin
          r_qi[i] <= '0;
          r_vi[i] <= cdb_data(r_qi[i]);
        end
        if (r_valid[i] && cdb_hit(r_qj[i])) begin
          r_qj[i] <= '0;
          r_vj[i] <= cdb_data(r_qj[i]);
        end
      end
      if (ena_rs && w_has_free) begin
        r_alias[w_free_idx] <= rd_alias_from_dsp;
        r_op[w_free_idx]    <= optype_from_dsp;
        r_pc[w_free_idx]    <= pc_from_dsp;
        r_imm[w_free_idx]   <= imm_from_dsp;
        r_qi[w_free_idx]    <= cdb_hit(Qi_from_dsp) ? '0 : Qi_from_dsp;
        r_vi[w_free_idx]    <= cdb_hit(Qi_from_dsp) ? cdb_data(Qi_from_dsp) : Vi_from_dsp;
        r_qj[w_free_idx]    <= cdb_hit(Qj_from_dsp) ? '0 : Qj_from_dsp;
        r_vj[w_free_idx]    <= cdb_hit(Qj_from_dsp) ? cdb_data(Qj_from_dsp) : Vj_from_dsp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= '0;
      ena_alu       <= 1'b0;
      rd_alias_2alu <= '0;
      optype_2alu   <= '0;
      pc_2alu       <= '0;
      Vi_2alu       <= '0;
      Vj_2alu       <= '0;
      imm_2alu      <= '0;
    end else if (rollback_signal) begin
      r_valid <= '0;
      ena_alu <= 1'b0;
    end else if (rdy) begin
      ena_alu <= w_has_sel;
      if (w_has_sel) begin
        r_valid[w_sel_idx] <= 1'b0;
        rd_alias_2alu      <= r_alias[w_sel_idx];
        optype_2alu        <= r_op[w_sel_idx];
        pc_2alu            <= r_pc[w_sel_idx];
        Vi_2alu            <= r_vi[w_sel_idx];
        Vj_2alu            <= r_vj[w_sel_idx];
        imm_2alu           <= r_imm[w_sel_idx];
      end
      // The free slot is never the selected one, both come from pre-edge state.
      if (ena_rs && w_has_free) r_valid[w_free_idx] <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && rdy && !rollback_signal && ena_rs && !w_has_free)
      $display("reservation_station: ERROR ena_rs with no free entry, request dropped");
  end
`endif

endmodule

`default_nettype wire
